// File: rtl/c16_run_ctrl.sv
// rtl/c16_run_ctrl.sv - run/step/breakpoint sequencer driving the c16 core clock enable
// Board inputs are synchronised here; fetch_pc is fed back from the fetcher.
module c16_run_ctrl #(
  parameter int PC_W        = 16,
  parameter int CNT_W       = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             CPU_RESET_n,
  input  logic             key_step_n,
  input  logic             run_sw,
  input  logic             cnt_clr,
  input  logic             bp_en,
  input  logic [PC_W-1:0]  bp_addr,
  input  logic [PC_W-1:0]  fetch_pc,
  input  logic [7:0]       step_count,
  output logic             core_en,
  output logic [1:0]       state,
  output logic             halted,
  output logic [CNT_W-1:0] cycle_cnt
);

  typedef enum logic [1:0] {
    ST_HALT  = 2'b00,
    ST_RUN   = 2'b01,
    ST_BREAK = 2'b10,
    ST_STEP  = 2'b11
  } state_t;

  logic [1:0]             r_rst_sync;
  logic                   w_rst_n;
  logic [SYNC_STAGES-1:0] r_key_sync;
  logic [SYNC_STAGES-1:0] r_run_sync;
  logic                   r_key_d;
  logic                   w_key_s;
  logic                   w_run_s;
  logic                   w_step_ev;
  logic                   w_bp_hit;
  logic [7:0]             w_step_load;
  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [7:0]             r_remain;
  logic [7:0]             w_remain_nxt;
  logic [CNT_W-1:0]       r_cycle_cnt;
  logic                   w_core_en;

  // Reset asserts asynchronously but releases on a clock edge.
  always_ff @(posedge clk or negedge CPU_RESET_n) begin
    if (!CPU_RESET_n) begin
      r_rst_sync <= 2'b00;
    end else begin
      r_rst_sync <= {r_rst_sync[0], 1'b1};
    end
  end

  assign w_rst_n = r_rst_sync[1];

  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_key_sync <= '1;
      r_run_sync <= '0;
      r_key_d    <= 1'b1;
    end else begin
      r_key_sync <= {r_key_sync[SYNC_STAGES-2:0], key_step_n};
      r_run_sync <= {r_run_sync[SYNC_STAGES-2:0], run_sw};
      r_key_d    <= w_key_s;
    end
  end

  assign w_key_s   = r_key_sync[SYNC_STAGES-1];
  assign w_run_s   = r_run_sync[SYNC_STAGES-1];
  assign w_step_ev = r_key_d & ~w_key_s;

  assign w_bp_hit    = bp_en && (fetch_pc == bp_addr);
  assign w_step_load = (step_count == 8'd0) ? 8'd1 : step_count;

  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_state  <= ST_HALT;
      r_remain <= 8'd0;
    end else begin
      r_state  <= w_state_nxt;
      r_remain <= w_remain_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_remain_nxt = r_remain;
    case (r_state)
      ST_HALT: begin
        if (w_run_s) begin
          w_state_nxt = ST_RUN;
        end else if (w_step_ev) begin
          w_state_nxt  = ST_STEP;
          w_remain_nxt = w_step_load;
        end
      end
      ST_RUN: begin
        if (!w_run_s) begin
          w_state_nxt = ST_HALT;
        end else if (w_bp_hit) begin
          w_state_nxt = ST_BREAK;
        end
      end
      ST_BREAK: begin
        if (!w_run_s) begin
          w_state_nxt = ST_HALT;
        end else if (w_step_ev) begin
          w_state_nxt  = ST_STEP;
          w_remain_nxt = w_step_load;
        end
      end
      ST_STEP: begin
        // Breakpoints and further key presses are deliberately ignored while stepping.
        if (r_remain <= 8'd1) begin
          w_state_nxt  = w_run_s ? ST_RUN : ST_HALT;
          w_remain_nxt = 8'd0;
        end else begin
          w_remain_nxt = r_remain - 8'd1;
        end
      end
      default: begin
        w_state_nxt  = ST_HALT;
        w_remain_nxt = 8'd0;
      end
    endcase
  end

  // Stall in the same cycle the PC matches, before the instruction at bp_addr issues.
  assign w_core_en = ((r_state == ST_RUN) && !w_bp_hit) || (r_state == ST_STEP);

  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_cycle_cnt <= '0;
    end else if (cnt_clr) begin
      r_cycle_cnt <= '0;
    end else if (w_core_en) begin
      r_cycle_cnt <= r_cycle_cnt + CNT_W'(1);
    end
  end

  assign core_en   = w_core_en;
  assign state     = r_state;
  assign halted    = (r_state == ST_HALT) || (r_state == ST_BREAK);
  assign cycle_cnt = r_cycle_cnt;

endmodule
